fft_spectrum_peak: RTL



---
 rtl/fft_post_pkg.sv | 35 +++
 rtl/fft_pwr_calc.sv | 97 +++++++++
 rtl/fft_spectrum_peak.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/fft_post_pkg.sv
// Shared constants and types for the post-FFT power/peak stage.
package fft_post_pkg;

    localparam int LOGS_FFT_LEN = 13;
    localparam int INPUT_WIDTH  = 10;

    // tuser field positions
    localparam int IDX_LSB = 0;
    localparam int EXP_LSB = 16;
    localparam int EXP_W   = 5;

    // tdata lane offsets
    localparam int RE_LSB = 0;
    localparam int IM_LSB = 16;

    // o_err bit indices
    localparam int ERR_IDX  = 0;
    localparam int ERR_LAST = 1;
    localparam int ERR_EXP  = 2;
    localparam int ERR_W    = 3;

    typedef enum logic {
        HUNT = 1'b0,
        RUN  = 1'b1
    } frame_state_t;

    // Per-beat decisions made at the input, carried alongside the power pipeline
    typedef struct packed {
        logic             start;
        logic             cand;
        logic             good_end;
        logic [EXP_W-1:0] blk_exp;
    } beat_tag_t;

endpackage

// File: rtl/fft_pwr_calc.sv
// Three-stage |X|^2 pipeline: register inputs, square each lane, sum.
// Valid, last and bin index travel with the data.
module fft_pwr_calc #(
    parameter int IDX_W  = fft_post_pkg::LOGS_FFT_LEN,
    parameter int DATA_W = fft_post_pkg::INPUT_WIDTH
) (
    input  logic                     i_aclk,
    input  logic                     i_aresetn,
    input  logic                     beat_valid,
    input  logic                     beat_last,
    input  logic [IDX_W-1:0]         beat_idx,
    input  logic signed [DATA_W-1:0] beat_re,
    input  logic signed [DATA_W-1:0] beat_im,
    output logic                     pwr_valid,
    output logic                     pwr_last,
    output logic [IDX_W-1:0]         pwr_idx,
    output logic [2*DATA_W-1:0]      pwr_data
);

    // A squared DATA_W-bit signed value never exceeds 2^(2*DATA_W-2)
    localparam int SQ_W = 2 * DATA_W - 1;

    logic                     s1_valid;
    logic                     s1_last;
    logic [IDX_W-1:0]         s1_idx;
    logic signed [DATA_W-1:0] s1_re;
    logic signed [DATA_W-1:0] s1_im;

    logic                     s2_valid;
    logic                     s2_last;
    logic [IDX_W-1:0]         s2_idx;
    logic [SQ_W-1:0]          s2_sq_re;
    logic [SQ_W-1:0]          s2_sq_im;

    logic signed [SQ_W-1:0]   re_ext;
    logic signed [SQ_W-1:0]   im_ext;
    logic [SQ_W-1:0]          sq_re;
    logic [SQ_W-1:0]          sq_im;

    // Stage 1: capture the beat
    always_ff @(posedge i_aclk) begin
        if (!i_aresetn) begin
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
            s1_idx   <= '0;
            s1_re    <= '0;
            s1_im    <= '0;
        end else begin
            s1_valid <= beat_valid;
            s1_last  <= beat_last;
            s1_idx   <= beat_idx;
            s1_re    <= beat_re;
            s1_im    <= beat_im;
        end
    end

    // Sign-extend to the product width and square
    always_comb begin
        re_ext = {{(SQ_W-DATA_W){s1_re[DATA_W-1]}}, s1_re};
        im_ext = {{(SQ_W-DATA_W){s1_im[DATA_W-1]}}, s1_im};
        sq_re  = re_ext * re_ext;
        sq_im  = im_ext * im_ext;
    end

    // Stage 2: register the squares
    always_ff @(posedge i_aclk) begin
        if (!i_aresetn) begin
            s2_valid <= 1'b0;
            s2_last  <= 1'b0;
            s2_idx   <= '0;
            s2_sq_re <= '0;
            s2_sq_im <= '0;
        end else begin
            s2_valid <= s1_valid;
            s2_last  <= s1_last;
            s2_idx   <= s1_idx;
            s2_sq_re <= sq_re;
            s2_sq_im <= sq_im;
        end
    end

    // Stage 3: sum into the full power width (cannot overflow)
    always_ff @(posedge i_aclk) begin
        if (!i_aresetn) begin
            pwr_valid <= 1'b0;
            pwr_last  <= 1'b0;
            pwr_idx   <= '0;
            pwr_data  <= '0;
        end else begin
            pwr_valid <= s2_valid;
            pwr_last  <= s2_last;
            pwr_idx   <= s2_idx;
            pwr_data  <= {1'b0, s2_sq_re} + {1'b0, s2_sq_im};
        end
    end

endmodule

// File: rtl/fft_spectrum_peak.sv
// Post-FFT stage: per-bin power stream, per-frame peak report and framing checks.
//
//   state | meaning
//   ------+----------------------------------------------------------------
//   HUNT  | waiting for a valid index-0 beat to open a frame
//   RUN   | inside a frame; every beat checked for index, tlast, exponent
module fft_spectrum_peak #(
    parameter int LOGS_FFT_LEN = fft_post_pkg::LOGS_FFT_LEN,
    parameter int INPUT_WIDTH  = fft_post_pkg::INPUT_WIDTH,
    parameter int HALF_ONLY    = 1,
    parameter int SKIP_DC      = 1,
    localparam int PWR_WIDTH   = 2 * INPUT_WIDTH
) (
    input  logic                    i_aclk,
    input  logic                    i_aresetn,
    input  logic                    i_axi4s_data_tvalid,
    input  logic [31:0]             i_axi4s_data_tdata,
    input  logic                    i_axi4s_data_tlast,
    input  logic [23:0]             i_axi4s_data_tuser,
    input  logic                    i_err_clr,
    output logic                    o_pwr_tvalid,
    output logic [PWR_WIDTH-1:0]    o_pwr_tdata,
    output logic                    o_pwr_tlast,
    output logic [LOGS_FFT_LEN-1:0] o_pwr_tuser,
    output logic                    o_peak_valid,
    output logic [LOGS_FFT_LEN-1:0] o_peak_idx,
    output logic [PWR_WIDTH-1:0]    o_peak_pwr,
    output logic [4:0]              o_peak_exp,
    output logic [2:0]              o_err,
    output logic [15:0]             o_frame_cnt
);

    import fft_post_pkg::*;

    localparam logic [LOGS_FFT_LEN-1:0] IDX_ZERO  = '0;
    localparam logic [LOGS_FFT_LEN-1:0] IDX_ONE   = LOGS_FFT_LEN'(1);
    localparam logic [LOGS_FFT_LEN-1:0] IDX_LAST  = '1;
    localparam logic [LOGS_FFT_LEN-1:0] IDX_HALF  = IDX_ONE << (LOGS_FFT_LEN - 1);
    localparam int                      TAG_DEPTH = 3;

    logic                          beat_valid;
    logic                          beat_last;
    logic [LOGS_FFT_LEN-1:0]       beat_idx;
    logic [EXP_W-1:0]              beat_exp;
    logic signed [INPUT_WIDTH-1:0] beat_re;
    logic signed [INPUT_WIDTH-1:0] beat_im;
    logic                          unused_in;

    assign beat_valid = i_axi4s_data_tvalid;
    assign beat_last  = i_axi4s_data_tlast;
    assign beat_idx   = i_axi4s_data_tuser[IDX_LSB +: LOGS_FFT_LEN];
    assign beat_exp   = i_axi4s_data_tuser[EXP_LSB +: EXP_W];
    assign beat_re    = i_axi4s_data_tdata[RE_LSB +: INPUT_WIDTH];
    assign beat_im    = i_axi4s_data_tdata[IM_LSB +: INPUT_WIDTH];
    // Padding bits of tdata/tuser carry no meaning here
    assign unused_in  = ^{i_axi4s_data_tdata, i_axi4s_data_tuser};

    frame_state_t            state;
    frame_state_t            state_nxt;
    logic [LOGS_FFT_LEN-1:0] exp_idx;
    logic [LOGS_FFT_LEN-1:0] exp_idx_nxt;
    logic [EXP_W-1:0]        exp_lat;
    logic [EXP_W-1:0]        exp_lat_nxt;
    logic [ERR_W-1:0]        err_set;
    logic                    in_range;
    beat_tag_t               tag_in;

    // Decide whether a bin index lies inside the peak search window
    always_comb begin
        in_range = 1'b1;
        if (HALF_ONLY != 0 && beat_idx > IDX_HALF) begin
            in_range = 1'b0;
        end
        if (SKIP_DC != 0 && beat_idx == IDX_ZERO) begin
            in_range = 1'b0;
        end
    end

    // Framing state, expected index and the exponent latched on bin 0
    always_ff @(posedge i_aclk) begin
        if (!i_aresetn) begin
            state   <= HUNT;
            exp_idx <= '0;
            exp_lat <= '0;
        end else begin
            state   <= state_nxt;
            exp_idx <= exp_idx_nxt;
            exp_lat <= exp_lat_nxt;
        end
    end

    // Next state, framing checks and the tag describing this beat
    always_comb begin
        state_nxt      = state;
        exp_idx_nxt    = exp_idx;
        exp_lat_nxt    = exp_lat;
        err_set        = '0;
        tag_in         = '0;
        tag_in.blk_exp = beat_exp;
        if (beat_valid) begin
            unique case (state)
                HUNT: begin
                    if (beat_idx == IDX_ZERO) begin
                        state_nxt    = RUN;
                        exp_idx_nxt  = IDX_ONE;
                        exp_lat_nxt  = beat_exp;
                        tag_in.start = 1'b1;
                        tag_in.cand  = in_range;
                    end
                end
                RUN: begin
                    err_set[ERR_IDX]  = (beat_idx != exp_idx);
                    err_set[ERR_LAST] = (beat_last != (beat_idx == IDX_LAST));
                    err_set[ERR_EXP]  = (beat_exp != exp_lat);
                    if (|err_set) begin
                        // a failing beat never reopens a frame, even at index 0
                        state_nxt = HUNT;
                    end else begin
                        tag_in.cand = in_range;
                        if (beat_idx == IDX_LAST) begin
                            tag_in.good_end = 1'b1;
                            state_nxt       = HUNT;
                        end else begin
                            exp_idx_nxt = exp_idx + IDX_ONE;
                        end
                    end
                end
            endcase
        end
    end

    // Sticky error flags; a new error beats a simultaneous clear
    always_ff @(posedge i_aclk) begin
        if (!i_aresetn) begin
            o_err <= '0;
        end else begin
            o_err <= (i_err_clr ? '0 : o_err) | err_set;
        end
    end

    fft_pwr_calc #(
        .IDX_W  (LOGS_FFT_LEN),
        .DATA_W (INPUT_WIDTH)
    ) u_pwr_calc (
        .i_aclk     (i_aclk),
        .i_aresetn  (i_aresetn),
        .beat_valid (beat_valid),
        .beat_last  (beat_last),
        .beat_idx   (beat_idx),
        .beat_re    (beat_re),
        .beat_im    (beat_im),
        .pwr_valid  (o_pwr_tvalid),
        .pwr_last   (o_pwr_tlast),
        .pwr_idx    (o_pwr_tuser),
        .pwr_data   (o_pwr_tdata)
    );

    beat_tag_t tag_pipe [TAG_DEPTH];
    beat_tag_t tag_out;

    assign tag_out = tag_pipe[TAG_DEPTH-1];

    // Delay the beat tags to line up with the power pipeline output
    always_ff @(posedge i_aclk) begin
        if (!i_aresetn) begin
            for (int i = 0; i < TAG_DEPTH; i++) begin
                tag_pipe[i] <= '0;
            end
        end else begin
            tag_pipe[0] <= tag_in;
            for (int i = 1; i < TAG_DEPTH; i++) begin
                tag_pipe[i] <= tag_pipe[i-1];
            end
        end
    end

    logic [PWR_WIDTH-1:0]    run_pwr;
    logic [LOGS_FFT_LEN-1:0] run_idx;
    logic [PWR_WIDTH-1:0]    base_pwr;
    logic [LOGS_FFT_LEN-1:0] base_idx;
    logic [PWR_WIDTH-1:0]    best_pwr;
    logic [LOGS_FFT_LEN-1:0] best_idx;

    // Running maximum including the current beat; strict compare keeps the lowest index
    always_comb begin
        base_pwr = tag_out.start ? '0 : run_pwr;
        base_idx = tag_out.start ? IDX_ZERO : run_idx;
        best_pwr = base_pwr;
        best_idx = base_idx;
        if (tag_out.cand && (o_pwr_tdata > base_pwr)) begin
            best_pwr = o_pwr_tdata;
            best_idx = o_pwr_tuser;
        end
    end

    // Track the frame maximum and publish it on a clean frame end
    always_ff @(posedge i_aclk) begin
        if (!i_aresetn) begin
            run_pwr      <= '0;
            run_idx      <= '0;
            o_peak_valid <= 1'b0;
            o_peak_idx   <= '0;
            o_peak_pwr   <= '0;
            o_peak_exp   <= '0;
            o_frame_cnt  <= '0;
        end else begin
            o_peak_valid <= tag_out.good_end;
            if (tag_out.start || tag_out.cand) begin
                run_pwr <= best_pwr;
                run_idx <= best_idx;
            end
            if (tag_out.good_end) begin
                o_peak_idx  <= best_idx;
                o_peak_pwr  <= best_pwr;
                o_peak_exp  <= tag_out.blk_exp;
                o_frame_cnt <= o_frame_cnt + 16'd1;
            end
        end
    end

endmodule
